seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
- Parametrised serial sequence detector; next generation of the lab-board fixed-pattern FSM detectors.
- Pattern and length are runtime-loadable, up to MAX_LEN bits.
- Selectable overlapping or non-overlapping detection, qualified input strobe, and a saturating match counter.
- Sits between a debounced switch/serial source and LEDR/HEX display logic; one bit is consumed per in_valid cycle.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of length fields; must satisfy 2**LEN_W > MAX_LEN.
- CNT_W, 8, match counter width.
- PAT_DEFAULT, 8'b0000_1101, pattern after reset (MAX_LEN bits, right-aligned).
- LEN_DEFAULT, 4, pattern length after reset.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pat_load  in  1  capture pat_in/pat_len this cycle.
- pat_in  in  MAX_LEN  new pattern, right-aligned; bit 0 = most recent bit.
- pat_len  in  LEN_W  new pattern length.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted bit.
- in_valid  in  1  w is a valid stream bit this cycle.
- w  in  1  serial input bit.
- match  out  1  one-cycle pulse, registered.
- match_count  out  CNT_W  saturating count of matches.
- fill  out  LEN_W  valid bits currently in window (0..len).

Behaviour:
- Reset values:
  - hist = 0, fill = 0, match = 0, match_count = 0.
  - pat_q = PAT_DEFAULT, len_q = LEN_DEFAULT.
  - All reset effects are immediate (asynchronous).
- Length clamp on load: pat_len = 0 → 1; pat_len > MAX_LEN → MAX_LEN.
- Accepted bit (in_valid=1, pat_load=0):
  - hist <= {hist[MAX_LEN-2:0], w}.
  - Window = {hist[len_q-2:0], w}, compared against pat_q[len_q-1:0]. Bits above len_q are ignored. Oldest window bit aligns to pat_q[len_q-1].
  - hit = (fill+1 >= len_q) and window equal.
  - match <= hit on the clock edge accepting the bit; latency is one cycle from the accepted bit's sampling edge.
- fill update on an accepted bit:
  - hit and overlap=0: fill <= 0. hist is retained but its bits are not eligible.
  - Otherwise: fill <= min(fill+1, len_q).
- No accepted bit: match <= 0; hist and fill hold.
- match_count increments on every hit and saturates at all-ones, with no wrap.
- pat_load=1:
  - pat_q and len_q capture the clamped values; hist <= 0, fill <= 0, match <= 0.
  - match_count is held.
  - Takes priority over in_valid in the same cycle; that bit is discarded.
- len_q = 1: every accepted bit equal to pat_q[0] matches. fill saturates at 1.
- A change of overlap mid-stream takes effect from the next accepted bit.
- Reset asserted mid-stream clears per reset values immediately. The first bit after deassertion starts a fresh window.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output sticky (1 bit).
  - sticky sets on any hit and holds until sticky_clr=1. Clear wins over a simultaneous hit.
  - Reset value 0. Intended for LEDR[9] on slow manual clocks.
- Undefined: neither port exists and no sticky logic is generated.

Test Plan:
- Default pattern 1101, len 4, overlap=1; stream 1,1,0,1 with in_valid=1 → match pulse one cycle after 4th bit; match_count=1; fill=4.
- Overlap=1, stream 1,1,0,1,1,0,1 → match after bits 4 and 7; match_count=2.
- Same stream with overlap=0 → match after bit 4 only; fill=0 after bit 4, 3 after bit 7; match_count=1.
- Load, then saturation:
  - pat_load with pat_in=8'b1010_1010, pat_len=8 and in_valid=1 in the same cycle → loaded bit discarded; fill=0.
  - Then 8 bits 1,0,1,0,1,0,1,0 → single match.
  - With pat_len=0 loaded → len_q=1.
- Instance CNT_W=2, len 1, pattern 1, five 1s → five match pulses; match_count stops at 3.
- Reset asserted between bits 3 and 4 of 1101 → outputs cleared without a clock edge; 4th bit alone gives no match; pattern returns to 1101.
- With SEQ_DET_STICKY_EN → sticky=1 after the match and held; sticky_clr and a hit in the same cycle → sticky=0.

Source files
------------

// File: rtl/seq_det_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_det_param                                                   |
// | Purpose  : Runtime-loadable serial pattern detector with saturating count. |
// |            Optional sticky flag enabled by defining SEQ_DET_STICKY_EN.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_det_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] PAT_DEFAULT = 8'b0000_1101,
  parameter logic [LEN_W-1:0]   LEN_DEFAULT = LEN_W'(4)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               w,
`ifdef SEQ_DET_STICKY_EN
  input  logic               sticky_clr,
  output logic               sticky,
`endif
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  // Only the newest MAX_LEN-1 history bits can ever join a window.
  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_eq;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_full;
  logic               w_hit;
  logic [LEN_W-1:0]   w_fill_nxt;

  assign w_accept = in_valid & ~pat_load;
  assign w_window = {r_hist, w};

  always_comb begin
    if (pat_len == '0)
      w_len_clamp = LEN_W'(1);
    else if (pat_len > LEN_W'(MAX_LEN))
      w_len_clamp = LEN_W'(MAX_LEN);
    else
      w_len_clamp = pat_len;
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_eq       = ((w_window ^ r_pat) & w_mask) == '0;
  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  assign w_full     = (w_fill_inc >= {1'b0, r_len});
  assign w_hit      = w_accept & w_eq & w_full;

  // A non-overlapping hit makes the retained history ineligible by zeroing fill.
  always_comb begin
    if (w_hit && !overlap)
      w_fill_nxt = '0;
    else if (w_full)
      w_fill_nxt = r_len;
    else
      w_fill_nxt = w_fill_inc[LEN_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_pat   <= PAT_DEFAULT;
      r_len   <= LEN_DEFAULT;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else if (pat_load) begin
      r_hist  <= '0;
      r_pat   <= pat_in;
      r_len   <= w_len_clamp;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (in_valid) begin
      r_hist  <= w_window[MAX_LEN-2:0];
      r_fill  <= w_fill_nxt;
      r_match <= w_hit;
      if (w_hit && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_match <= 1'b0;
    end
  end

`ifdef SEQ_DET_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_sticky <= 1'b0;
    else if (sticky_clr)
      r_sticky <= 1'b0;
    else if (w_hit)
      r_sticky <= 1'b1;
  end

  assign sticky = r_sticky;
`endif

  assign match       = r_match;
  assign match_count = r_cnt;
  assign fill        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_det_param                                                |
// | Purpose  : Randomised and directed bench for seq_det_param against a       |
// |            queue-based reference model.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_det_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       pat_load, overlap, in_valid, w, sticky_clr;
  logic [7:0] pat_in;
  logic [3:0] pat_len;
  logic       match;
  logic [7:0] match_count;
  logic [3:0] fill;
`ifdef SEQ_DET_STICKY_EN
  logic       sticky, s_sticky;
`endif

  logic       s_load, s_valid, s_w;
  logic [7:0] s_pat_in;
  logic [3:0] s_pat_len;
  logic       s_match;
  logic [1:0] s_count;
  logic [3:0] s_fill;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bits accepted since the last window restart.
  bit       m_q[$];
  bit [7:0] m_pat;
  int       m_len;
  int       m_cnt;
  bit       m_match;
  bit       m_sticky;

  always #5 clock = ~clock;

  seq_det_param u_dut (
    .clock       (clock),
    .reset       (reset),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .in_valid    (in_valid),
    .w           (w),
`ifdef SEQ_DET_STICKY_EN
    .sticky_clr  (sticky_clr),
    .sticky      (sticky),
`endif
    .match       (match),
    .match_count (match_count),
    .fill        (fill)
  );

  seq_det_param #(.CNT_W(2)) u_sat (
    .clock       (clock),
    .reset       (reset),
    .pat_load    (s_load),
    .pat_in      (s_pat_in),
    .pat_len     (s_pat_len),
    .overlap     (1'b1),
    .in_valid    (s_valid),
    .w           (s_w),
`ifdef SEQ_DET_STICKY_EN
    .sticky_clr  (1'b0),
    .sticky      (s_sticky),
`endif
    .match       (s_match),
    .match_count (s_count),
    .fill        (s_fill)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pat    = 8'b0000_1101;
    m_len    = 4;
    m_cnt    = 0;
    m_match  = 1'b0;
    m_sticky = 1'b0;
  endtask

  function automatic int model_fill();
    return (m_q.size() < m_len) ? m_q.size() : m_len;
  endfunction

  task automatic model_edge(input bit ld, input bit [7:0] pin, input bit [3:0] plen,
                            input bit ov, input bit iv, input bit wb, input bit clr);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = pin;
      m_len = (plen == 0) ? 1 : ((plen > 8) ? 8 : int'(plen));
      m_q.delete();
    end else if (iv) begin
      m_q.push_back(wb);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size()-1-k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (!ov) m_q.delete();
      end
    end
    m_match = hit;
    if (clr) m_sticky = 1'b0;
    else if (hit) m_sticky = 1'b1;
  endtask

  task automatic step(input bit ld, input bit [7:0] pin, input bit [3:0] plen,
                      input bit ov, input bit iv, input bit wb, input bit clr);
    pat_load = ld; pat_in = pin; pat_len = plen;
    overlap = ov; in_valid = iv; w = wb; sticky_clr = clr;
    @(posedge clock);
    model_edge(ld, pin, plen, ov, iv, wb, clr);
    #1;
    check_value("match", match, m_match);
    check_value("match_count", match_count, m_cnt);
    check_value("fill", fill, model_fill());
`ifdef SEQ_DET_STICKY_EN
    check_value("sticky", sticky, m_sticky);
`endif
  endtask

  task automatic bit_in(input bit ov, input bit wb);
    step(1'b0, 8'h00, 4'd0, ov, 1'b1, wb, 1'b0);
  endtask

  task automatic step_sat(input bit ld, input bit iv, input bit wb);
    s_load = ld; s_valid = iv; s_w = wb;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pat_load = 1'b0; pat_in = '0; pat_len = '0; overlap = 1'b1;
    in_valid = 1'b0; w = 1'b0; sticky_clr = 1'b0;
    s_load = 1'b0; s_valid = 1'b0; s_w = 1'b0; s_pat_in = 8'h01; s_pat_len = 4'd1;
    model_reset();
    #12;
    check_value("rst_match", match, 0);
    check_value("rst_count", match_count, 0);
    check_value("rst_fill", fill, 0);
    reset = 1'b0;

    // Default pattern, overlapping: 1,1,0,1 then 1,0,1
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 0); bit_in(1, 1);
    check_value("tp1_match", match, 1);
    check_value("tp1_count", match_count, 1);
    check_value("tp1_fill", fill, 4);
    bit_in(1, 1); bit_in(1, 0); bit_in(1, 1);
    check_value("tp2_match", match, 1);
    check_value("tp2_count", match_count, 2);

    // Non-overlapping on the same stream after a restart
    step(1, 8'b0000_1101, 4'd4, 0, 0, 0, 0);
    bit_in(0, 1); bit_in(0, 1); bit_in(0, 0); bit_in(0, 1);
    check_value("tp3_fill4", fill, 0);
    bit_in(0, 1); bit_in(0, 0); bit_in(0, 1);
    check_value("tp3_match7", match, 0);
    check_value("tp3_fill7", fill, 3);
    check_value("tp3_count", match_count, 3);

    // Load with a simultaneous valid bit, then 8-bit pattern
    step(1, 8'b1010_1010, 4'd8, 1, 1, 1, 0);
    check_value("tp4_fill", fill, 0);
    for (int i = 0; i < 8; i++) bit_in(1, (i % 2) == 0);
    check_value("tp4_match", match, 1);
    check_value("tp4_count", match_count, 4);

    // Zero length clamps to one
    step(1, 8'h01, 4'd0, 1, 0, 0, 0);
    bit_in(1, 1);
    check_value("len0_match", match, 1);
    check_value("len0_fill", fill, 1);
    bit_in(1, 0);
    bit_in(1, 1);

    // Asynchronous reset mid-stream
    step(1, 8'b0000_1101, 4'd4, 1, 0, 0, 0);
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_value("arst_count", match_count, 0);
    check_value("arst_fill", fill, 0);
    check_value("arst_match", match, 0);
    #1 reset = 1'b0;
    bit_in(1, 1);
    check_value("arst_nomatch", match, 0);
    bit_in(1, 1); bit_in(1, 0); bit_in(1, 1);
    check_value("arst_default_pat", match, 1);

`ifdef SEQ_DET_STICKY_EN
    step(0, 8'h00, 4'd0, 1, 0, 0, 0);
    step(0, 8'h00, 4'd0, 1, 0, 0, 0);
    check_value("sticky_hold", sticky, 1);
    step(1, 8'h01, 4'd1, 1, 0, 0, 0);
    step(0, 8'h00, 4'd0, 1, 1, 1, 1);
    check_value("sticky_clr_wins", sticky, 0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 20) == 0, 8'($urandom), 4'($urandom), 1'($urandom),
           ($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0);
    end

    // Saturating counter instance: pattern 1, length 1
    step_sat(1, 1, 1);
    check_value("sat_load_fill", s_fill, 0);
    for (int i = 1; i <= 5; i++) begin
      step_sat(0, 1, 1);
      check_value("sat_match", s_match, 1);
      check_value("sat_count", s_count, (i > 3) ? 3 : i);
    end
    step_sat(0, 0, 0);
    check_value("sat_idle_match", s_match, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
